// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, iterative-unit modes and FSM state encoding for seq_alu.
package seq_alu_pkg;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    // Mode of the iterative unit
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per step.
// After WIDTH steps {hi, lo} holds the full product (MUL) or remainder/quotient (DIV).
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             count_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] opb_q;
    logic             mode_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_t;
    logic             div_ge;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH-1:0] hi_nx;

    // Asserted while the step in progress is the one that brings the counter to zero,
    // so the controller can leave RUN on the same edge as the final step.
    assign count_zero = (cnt_q == CW'(1));

    assign lo = lo_q;
    assign hi = hi_q;

    // One iteration of either algorithm, selected by the latched mode
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_t   = {hi_q, lo_q[WIDTH-1]};
        div_ge  = (div_t >= {1'b0, opb_q});
        // Difference fits in WIDTH bits whenever it is taken (partial remainder < divisor)
        div_r   = div_ge ? (div_t[WIDTH-1:0] - opb_q) : div_t[WIDTH-1:0];
        lo_nx   = lo_q;
        hi_nx   = hi_q;
        if (mode_q == MODE_DIV) begin
            hi_nx = div_r;
            lo_nx = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Iteration counter: loaded with WIDTH, counts steps down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(WIDTH);
        end else if (step && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Partial product / remainder registers; lo starts as multiplier or dividend
    always_ff @(posedge clk) begin
        if (load) begin
            lo_q   <= a;
            hi_q   <= '0;
            opb_q  <= b;
            mode_q <= mode;
        end else if (step) begin
            lo_q   <= lo_nx;
            hi_q   <= hi_nx;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub plus iterative MUL/DIV, with result flags.
// All outputs come from registers; f/f_hi select between the single-cycle result
// registers and the iterative unit's registers depending on the last accepted op.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_hi,
    output logic             zero,
    output logic             carry,
    output logic             dbz
);

    state_t state, state_nx;

    logic             accept;
    logic             multi;
    logic             load;
    logic             step;
    logic             count_zero;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH-1:0] sc_f;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_carry;
    logic             sc_dbz;

    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] hi_r;
    logic             carry_r;
    logic             dbz_r;
    logic             use_md;

    assign accept = start && (state != RUN);
    // DIV by zero is resolved in one cycle and never enters RUN
    assign multi  = (oc == OC_MUL) || ((oc == OC_DIV) && (b != '0));

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .mode       (oc == OC_DIV),
        .load       (load),
        .step       (step),
        .lo         (md_lo),
        .hi         (md_hi),
        .count_zero (count_zero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and iterative-unit control; DONE accepts start just like IDLE
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (multi) begin
                        state_nx = RUN;
                        load     = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_zero) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle results, truncated to WIDTH; carry doubles as SUB borrow
    always_comb begin
        sc_f     = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_dbz   = 1'b0;
        case (oc)
            OC_ADD: {sc_carry, sc_f} = {1'b0, a} + {1'b0, b};
            OC_SUB: {sc_carry, sc_f} = {1'b0, a} - {1'b0, b};
            OC_NOT: sc_f = ~a;
            OC_XOR: sc_f = a ^ b;
            OC_OR:  sc_f = a | b;
            OC_AND: sc_f = a & b;
            OC_DIV: begin
                sc_f   = '1;
                sc_hi  = a;
                sc_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    // Result and flag registers, updated only on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_r     <= '0;
            hi_r    <= '0;
            carry_r <= 1'b0;
            dbz_r   <= 1'b0;
            use_md  <= 1'b0;
        end else if (accept) begin
            if (multi) begin
                use_md  <= 1'b1;
                carry_r <= 1'b0;
                dbz_r   <= 1'b0;
            end else begin
                use_md  <= 1'b0;
                f_r     <= sc_f;
                hi_r    <= sc_hi;
                carry_r <= sc_carry;
                dbz_r   <= sc_dbz;
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign f     = use_md ? md_lo : f_r;
    assign f_hi  = use_md ? md_hi : hi_r;
    assign zero  = (f == '0);
    assign carry = carry_r;
    assign dbz   = dbz_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed literal cases plus random traffic
// compared every cycle against a behavioural model built from integer arithmetic.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   oc = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, carry, dbz;
    logic [W-1:0] f, f_hi;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .oc    (oc),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .f_hi  (f_hi),
        .zero  (zero),
        .carry (carry),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_busy = 0, m_left = 0, m_done = 0;
    int m_f = 0, m_hi = 0, m_zero = 1, m_carry = 0, m_dbz = 0;
    int p_f = 0, p_hi = 0;

    always @(posedge clk or posedge rst) begin
        int ia, ib, r;
        if (rst) begin
            m_busy = 0; m_left = 0; m_done = 0;
            m_f = 0; m_hi = 0; m_zero = 1; m_carry = 0; m_dbz = 0;
        end else begin
            m_done = 0;
            if (m_busy != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_f = p_f; m_hi = p_hi; m_zero = (p_f == 0);
                    m_carry = 0; m_dbz = 0;
                end
            end else if (start) begin
                ia = int'(a);
                ib = int'(b);
                if (oc == 3'd2 || (oc == 3'd3 && ib != 0)) begin
                    m_busy = 1; m_left = W;
                    if (oc == 3'd2) begin
                        r = ia * ib; p_f = r % 256; p_hi = r / 256;
                    end else begin
                        p_f = ia / ib; p_hi = ia % ib;
                    end
                end else begin
                    m_done = 1; m_hi = 0; m_carry = 0; m_dbz = 0;
                    case (oc)
                        3'd0: begin r = ia + ib; m_f = r % 256; m_carry = (r > 255); end
                        3'd1: begin m_f = (ia - ib + 256) % 256; m_carry = (ia < ib); end
                        3'd3: begin m_f = 255; m_hi = ia; m_dbz = 1; end
                        3'd4: m_f = 255 - ia;
                        3'd5: m_f = ia ^ ib;
                        3'd6: m_f = ia | ib;
                        default: m_f = ia & ib;
                    endcase
                    m_zero = (m_f == 0);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (m_busy == 0) begin
            chk("f", f, m_f);
            chk("f_hi", f_hi, m_hi);
            chk("zero", zero, m_zero);
            chk("carry", carry, m_carry);
            chk("dbz", dbz, m_dbz);
        end
    end

    // Issue one op, scramble inputs afterwards, wait (bounded) for done
    task automatic run_op(input logic [2:0] op, input int ia, input int ib, input bit poke,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; oc = op; a = W'(ia); b = W'(ib);
        lat = 0; nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            start = poke && (lat == 3);
            oc = 3'($urandom); a = W'($urandom); b = W'($urandom);
        end while (!done && lat < 40);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, nb, t0, gap, ndone;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_f", f, 0); chk("rst_zero", zero, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_fhi", f_hi, 0); chk("rst_dbz", dbz, 0);
        // start present at the first edge after reset release
        #2 rst = 1'b0; start = 1'b1; oc = 3'd0; a = 8'd200; b = 8'd100;
        @(negedge clk);
        chk("add_done", done, 1); chk("add_f", f, 8'h2C); chk("add_carry", carry, 1);
        chk("add_zero", zero, 0); chk("add_fhi", f_hi, 0);
        start = 1'b0;

        run_op(3'd1, 3, 5, 0, lat, nb);
        chk("sub35_f", f, 8'hFE); chk("sub35_carry", carry, 1); chk("sub35_lat", lat, 1);
        run_op(3'd1, 5, 5, 0, lat, nb);
        chk("sub55_f", f, 0); chk("sub55_zero", zero, 1); chk("sub55_carry", carry, 0);

        run_op(3'd2, 200, 3, 1, lat, nb);
        chk("mul_lat", lat, 9); chk("mul_busy_cycles", nb, 8);
        chk("mul_f", f, 8'h58); chk("mul_fhi", f_hi, 8'h02);

        run_op(3'd3, 100, 7, 0, lat, nb);
        chk("div_lat", lat, 9); chk("div_f", f, 14); chk("div_fhi", f_hi, 2); chk("div_dbz", dbz, 0);
        run_op(3'd3, 100, 0, 0, lat, nb);
        chk("dbz_lat", lat, 1); chk("dbz_f", f, 8'hFF); chk("dbz_fhi", f_hi, 100); chk("dbz_flag", dbz, 1);

        // reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; oc = 3'd2; a = 8'd15; b = 8'd17;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_f", f, 0);
        chk("abort_fhi", f_hi, 0); chk("abort_zero", zero, 1); chk("abort_carry", carry, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (12) begin @(negedge clk); if (done) ndone++; end
        chk("abort_no_done", ndone, 0);
        run_op(3'd2, 15, 17, 0, lat, nb);
        chk("mul2_f", f, 8'hFF); chk("mul2_fhi", f_hi, 0); chk("mul2_lat", lat, 9);

        // start held high: next op accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; oc = 3'd2; a = 8'd13; b = 8'd11;
        t0 = 0;
        while (!done && t0 < 40) begin @(negedge clk); t0++; end
        chk("b2b_first", done, 1);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 40);
        chk("b2b_gap", gap, 9); chk("b2b_f", f, 143); chk("b2b_fhi", f_hi, 0);
        start = 1'b0;

        // random traffic, including occasional resets
        repeat (600) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            oc = 3'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
